// File: rtl/apb_modport.sv
// rtl/apb_modport.sv - request/response to APB master bridge (IDLE/SETUP/ACCESS)
// Optional unaligned-address error check: define APB_ALIGN_CHECK_EN.
module apb_modport (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] Pselx,
    output logic        Penable,
    output logic        Pwrite,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    input  logic [31:0] Prdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;
    logic   accept;
    logic   unaligned;
    logic   launch;

    assign accept = req_valid && req_ready;

`ifdef APB_ALIGN_CHECK_EN
    logic err_pend;
    logic err_q;
    assign unaligned = (req_addr[1:0] != 2'b00);
    assign rsp_err   = err_q;
`else
    assign unaligned = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    assign launch = accept && !unaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            Pselx     <= 32'd0;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= 32'd0;
            Pwdata    <= 32'd0;
`ifdef APB_ALIGN_CHECK_EN
            err_pend  <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef APB_ALIGN_CHECK_EN
            err_q     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (launch) begin
                        state     <= SETUP;
                        req_ready <= 1'b0;
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    Penable   <= 1'b1;
                    req_ready <= 1'b1;
                end
                ACCESS: begin
                    // Pwrite still belongs to the completing transfer at this edge
                    Penable   <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= Pwrite ? 32'd0 : Prdata;
                    if (launch) begin
                        state     <= SETUP;
                        req_ready <= 1'b0;
                    end else begin
                        state <= IDLE;
                        Pselx <= 32'd0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    Pselx     <= 32'd0;
                    Penable   <= 1'b0;
                end
            endcase

            if (launch) begin
                Paddr  <= req_addr;
                Pwrite <= req_write;
                Pwdata <= req_write ? req_wdata : 32'd0;
                Pselx  <= 32'd1 << req_addr[31:27];
            end

`ifdef APB_ALIGN_CHECK_EN
            // An error accepted in ACCESS collides with the completing response, so it is deferred a cycle
            if (err_pend) begin
                err_pend  <= 1'b0;
                req_ready <= 1'b1;
                rsp_valid <= 1'b1;
                err_q     <= 1'b1;
                rsp_rdata <= 32'd0;
            end else if (accept && unaligned) begin
                if (state == ACCESS) begin
                    err_pend  <= 1'b1;
                    req_ready <= 1'b0;
                end else begin
                    rsp_valid <= 1'b1;
                    err_q     <= 1'b1;
                    rsp_rdata <= 32'd0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_apb_modport.sv
// tb/tb_apb_modport.sv - randomized bench for apb_modport with transaction-timeline model
module tb_apb_modport;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata = 32'd0;

    always #5 clk = ~clk;

    apb_modport dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Prdata    (Prdata)
    );

    // Each accepted transfer is remembered with the edge index it was accepted on;
    // its SETUP, ACCESS and response cycles follow at fixed offsets from that edge.
    typedef struct {
        int          a;
        logic [31:0] addr;
        logic        w;
        logic [31:0] wd;
        logic [31:0] rd;
    } txn_t;

    txn_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          n = 0;
    int          err_at = -10;
    bit          rst_pend = 1'b0;
    logic        m_ready = 1'b0;
    logic        m_pwrite = 1'b0;
    logic [31:0] m_paddr = 32'd0;
    logic [31:0] m_pwdata = 32'd0;
    logic [31:0] m_rdata = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
        end
    endtask

    task automatic model_compare();
        int          si = -1;
        int          ai = -1;
        int          ri = -1;
        logic [31:0] esel;
        if (rst_pend) begin
            q.delete();
            m_paddr  = 32'd0;
            m_pwdata = 32'd0;
            m_pwrite = 1'b0;
            m_rdata  = 32'd0;
            err_at   = -10;
            rst_pend = 1'b0;
        end
        while (q.size() > 0 && q[0].a + 2 < n) void'(q.pop_front());
        foreach (q[i]) begin
            if (q[i].a == n)     si = i;
            if (q[i].a + 1 == n) ai = i;
            if (q[i].a + 2 == n) ri = i;
        end
        esel = 32'd0;
        if (si >= 0)      esel = 32'd1 << q[si].addr[31:27];
        else if (ai >= 0) esel = 32'd1 << q[ai].addr[31:27];
        if (ri >= 0)      m_rdata = q[ri].w ? 32'd0 : q[ri].rd;
        if (err_at == n)  m_rdata = 32'd0;
        m_ready = (si < 0);
        chk("req_ready", req_ready, m_ready);
        chk("Pselx", Pselx, esel);
        chk("Penable", Penable, ai >= 0);
        chk("Paddr", Paddr, m_paddr);
        chk("Pwrite", Pwrite, m_pwrite);
        chk("Pwdata", Pwdata, m_pwdata);
        chk("rsp_valid", rsp_valid, (ri >= 0) || (err_at == n));
        chk("rsp_err", rsp_err, err_at == n);
        chk("rsp_rdata", rsp_rdata, m_rdata);
    endtask

    // Drive one cycle of inputs at the falling edge, update the model, check after the next edge.
    task automatic step(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] p, input bit r);
        bit bad;
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        Prdata    = p;
        rst       = r;
        bad = 1'b0;
`ifdef APB_ALIGN_CHECK_EN
        bad = (a[1:0] != 2'b00);
`endif
        foreach (q[i]) if (q[i].a + 1 == n) q[i].rd = p;
        if (r) begin
            rst_pend = 1'b1;
        end else if (v && m_ready) begin
            if (bad) begin
                err_at = n + 1;
            end else begin
                q.push_back('{n + 1, a, w, d, 32'd0});
                m_paddr  = a;
                m_pwrite = w;
                m_pwdata = w ? d : 32'd0;
            end
        end
        @(posedge clk);
        n++;
        @(negedge clk);
        model_compare();
    endtask

    logic [7:0]  pen;
    logic [7:0]  rv;
    logic [31:0] ra;

    initial begin
        step(0, 0, 32'd0, 32'd0, 32'd0, 1);
        chk("reset_ready", req_ready, 1);
        chk("reset_pselx", Pselx, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        step(0, 0, 32'd0, 32'd0, 32'd0, 0);

        step(1, 1, 32'h0800_0010, 32'hDEAD_BEEF, 32'd0, 0);
        chk("wr_setup_pselx", Pselx, 32'h0000_0002);
        chk("wr_setup_penable", Penable, 0);
        chk("wr_setup_pwdata", Pwdata, 32'hDEAD_BEEF);
        step(0, 0, 32'd0, 32'd0, 32'd0, 0);
        chk("wr_access_penable", Penable, 1);
        step(0, 0, 32'd0, 32'd0, 32'd0, 0);
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_rdata", rsp_rdata, 32'd0);

        step(1, 0, 32'hF800_0000, 32'h5555_5555, 32'd0, 0);
        chk("rd_setup_pselx", Pselx, 32'h8000_0000);
        chk("rd_setup_pwdata", Pwdata, 32'd0);
        step(0, 0, 32'd0, 32'd0, 32'd0, 0);
        step(0, 0, 32'd0, 32'd0, 32'h1234_5678, 0);
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
        step(0, 0, 32'd0, 32'd0, 32'hFFFF_FFFF, 0);
        chk("rd_rsp_hold", rsp_rdata, 32'h1234_5678);

        pen = 8'd0;
        rv  = 8'd0;
        for (int i = 0; i < 8; i++) begin
            ra = {5'(i + 3), 27'(i * 16)};
            step(i < 5, 1'b0, ra, 32'hA000_0000 + 32'(i), 32'h100 + 32'(i), 0);
            pen = {pen[6:0], Penable};
            rv  = {rv[6:0], rsp_valid};
            if (i < 6) chk("b2b_psel_nonzero", Pselx != 0, 1);
        end
        chk("b2b_penable_pattern", pen, 8'b0101_0100);
        chk("b2b_rsp_pattern", rv, 8'b0010_1010);

        step(1, 1, 32'h1000_0000, 32'h0000_0001, 32'd0, 0);
        step(0, 0, 32'd0, 32'd0, 32'd0, 0);
        chk("pre_rst_penable", Penable, 1);
        step(0, 0, 32'd0, 32'd0, 32'd0, 1);
        chk("rst_access_pselx", Pselx, 0);
        chk("rst_access_penable", Penable, 0);
        chk("rst_access_paddr", Paddr, 0);
        chk("rst_access_pwdata", Pwdata, 0);
        chk("rst_access_rsp_valid", rsp_valid, 0);
        step(0, 0, 32'd0, 32'd0, 32'd0, 0);
        chk("rst_access_no_rsp", rsp_valid, 0);

        step(1, 1, 32'h0000_0003, 32'h0000_0077, 32'd0, 0);
`ifdef APB_ALIGN_CHECK_EN
        chk("unaligned_pselx", Pselx, 0);
        chk("unaligned_rsp_valid", rsp_valid, 1);
        chk("unaligned_rsp_err", rsp_err, 1);
`else
        chk("unaligned_pselx", Pselx, 32'd1);
        chk("unaligned_paddr", Paddr, 32'h0000_0003);
        step(0, 0, 32'd0, 32'd0, 32'd0, 0);
        step(0, 0, 32'd0, 32'd0, 32'd0, 0);
        chk("unaligned_rsp_valid", rsp_valid, 1);
        chk("unaligned_rsp_err", rsp_err, 0);
`endif

        for (int i = 0; i < 3000; i++) begin
            ra = $urandom;
`ifdef APB_ALIGN_CHECK_EN
            ra[1:0] = 2'b00;
`endif
            step($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, ra, $urandom, $urandom,
                 $urandom_range(0, 63) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
